// File: rtl/corr_pkt_decoder_pkg.sv
// Shared correlator packet definitions: byte count, byte positions and the decoded field struct.
package corrPkg;

  localparam int unsigned PKT_NBYTES = 5;

  localparam int unsigned PKTIDX_WINNUM  = 0;
  localparam int unsigned PKTIDX_COUNTX  = 1;
  localparam int unsigned PKTIDX_COUNTY  = 2;
  localparam int unsigned PKTIDX_ISECT   = 3;
  localparam int unsigned PKTIDX_SYMDIFF = 4;

  typedef struct packed {
    logic [7:0] win_num;
    logic [7:0] count_x;
    logic [7:0] count_y;
    logic [7:0] count_isect;
    logic [7:0] count_symdiff;
  } corr_pkt_t;

endpackage

// File: rtl/corr_pkt_dropcheck.sv
// Window-number continuity checker: pulses on a gap and keeps a saturating missing-window total.
module corr_pkt_dropcheck #(
  parameter int unsigned DropCntW = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cg_i,
  input  logic                load_i,
  input  logic [7:0]          win_num_i,
  input  logic                rearm_i,
  output logic                dropped_o,
  output logic [DropCntW-1:0] drop_count_o
);

  localparam int unsigned SumW = ((DropCntW > 8) ? DropCntW : 8) + 1;
  localparam logic [SumW-1:0] CntMax = SumW'({DropCntW{1'b1}});

  logic [7:0]          prev_q, prev_d;
  logic                first_q, first_d;
  logic                dropped_q, dropped_d;
  logic [DropCntW-1:0] count_q, count_d;
  logic [7:0]          gap;
  logic [SumW-1:0]     sum;

  // Modulo-256 gap: 255 -> 0 is contiguous.
  assign gap = win_num_i - prev_q - 8'd1;
  assign sum = SumW'(count_q) + SumW'(gap);

  always_comb begin
    prev_d    = prev_q;
    first_d   = first_q;
    dropped_d = dropped_q;
    count_d   = count_q;
    if (cg_i) begin
      dropped_d = 1'b0;
      if (rearm_i) begin
        first_d = 1'b1;
      end else if (load_i) begin
        prev_d  = win_num_i;
        first_d = 1'b0;
        if (!first_q && (gap != 8'd0)) begin
          dropped_d = 1'b1;
          count_d   = (sum > CntMax) ? {DropCntW{1'b1}} : sum[DropCntW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q    <= 8'd0;
      first_q   <= 1'b1;
      dropped_q <= 1'b0;
      count_q   <= '0;
    end else begin
      prev_q    <= prev_d;
      first_q   <= first_d;
      dropped_q <= dropped_d;
      count_q   <= count_d;
    end
  end

  // The pulse is masked while the clock gate is closed.
  assign dropped_o    = dropped_q && cg_i;
  assign drop_count_o = count_q;

endmodule

// File: rtl/corr_pkt_decoder.sv
// Correlator packet decoder: five-byte stream to field register with valid/ready handshake.
// Drop checking is built only when CORR_PKT_DECODER_DROPCHECK_EN is defined.
module corr_pkt_decoder #(
  parameter int unsigned DROPCNT_W  = 8,
  parameter int unsigned PKT_NBYTES = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cg,
  input  logic                 i_flush,
  input  logic [7:0]           i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [7:0]           o_winNum,
  output logic [7:0]           o_countX,
  output logic [7:0]           o_countY,
  output logic [7:0]           o_countIsect,
  output logic [7:0]           o_countSymdiff,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_dropped,
  output logic [DROPCNT_W-1:0] o_dropCount
);

  import corrPkg::*;

  localparam int unsigned LastIdx = PKT_NBYTES - 1;

  logic [2:0]      byte_idx_q, byte_idx_d;
  logic [3:0][7:0] stage_q, stage_d;
  corr_pkt_t       pkt_q, pkt_d;
  logic            valid_q, valid_d;
  logic            last_byte, accept, load;

  assign last_byte = (byte_idx_q == 3'(LastIdx));
  // Only the final byte can stall, and only when the held packet is not being taken.
  assign o_ready   = i_cg && !i_flush && !(last_byte && valid_q && !i_ready);
  assign accept    = i_valid && o_ready;
  assign load      = accept && last_byte;

  always_comb begin
    byte_idx_d = byte_idx_q;
    stage_d    = stage_q;
    pkt_d      = pkt_q;
    valid_d    = valid_q;
    if (i_cg) begin
      if (i_flush) begin
        byte_idx_d = 3'd0;
        stage_d    = '0;
        valid_d    = 1'b0;
      end else begin
        if (valid_q && i_ready) begin
          valid_d = 1'b0;
        end
        if (accept) begin
          if (last_byte) begin
            byte_idx_d          = 3'd0;
            pkt_d.win_num       = stage_q[PKTIDX_WINNUM];
            pkt_d.count_x       = stage_q[PKTIDX_COUNTX];
            pkt_d.count_y       = stage_q[PKTIDX_COUNTY];
            pkt_d.count_isect   = stage_q[PKTIDX_ISECT];
            pkt_d.count_symdiff = i_data;
            valid_d             = 1'b1;
          end else begin
            stage_d[byte_idx_q[1:0]] = i_data;
            byte_idx_d               = byte_idx_q + 3'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      byte_idx_q <= 3'd0;
      stage_q    <= '0;
      pkt_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      byte_idx_q <= byte_idx_d;
      stage_q    <= stage_d;
      pkt_q      <= pkt_d;
      valid_q    <= valid_d;
    end
  end

  assign o_valid        = valid_q;
  assign o_winNum       = pkt_q.win_num;
  assign o_countX       = pkt_q.count_x;
  assign o_countY       = pkt_q.count_y;
  assign o_countIsect   = pkt_q.count_isect;
  assign o_countSymdiff = pkt_q.count_symdiff;

`ifdef CORR_PKT_DECODER_DROPCHECK_EN
  corr_pkt_dropcheck #(
    .DropCntW (DROPCNT_W)
  ) u_dropcheck (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .cg_i         (i_cg),
    .load_i       (load),
    .win_num_i    (stage_q[PKTIDX_WINNUM]),
    .rearm_i      (i_flush),
    .dropped_o    (o_dropped),
    .drop_count_o (o_dropCount)
  );
`else
  logic unused_load;
  assign unused_load = load;
  assign o_dropped   = 1'b0;
  assign o_dropCount = '0;
`endif

endmodule

// File: tb/tb_corr_pkt_decoder.sv
// Bench for corr_pkt_decoder: directed packet scenarios plus randomized traffic against a queue model.
module tb_corr_pkt_decoder;

`ifdef CORR_PKT_DECODER_DROPCHECK_EN
  localparam bit DropEn = 1'b1;
`else
  localparam bit DropEn = 1'b0;
`endif
  localparam int CntMax = 255;

  logic       i_clk = 1'b0;
  logic       i_rst, i_cg, i_flush, i_valid, i_ready;
  logic [7:0] i_data;
  logic       o_ready, o_valid, o_dropped;
  logic [7:0] o_winNum, o_countX, o_countY, o_countIsect, o_countSymdiff;
  logic [7:0] o_dropCount;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [7:0]  mq[$];
  logic [39:0] m_pkt;
  logic        m_valid, m_first, m_pend;
  logic [7:0]  m_prev;
  int          m_count;

  always #5 i_clk = ~i_clk;

  corr_pkt_decoder #(
    .DROPCNT_W  (8),
    .PKT_NBYTES (5)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_cg           (i_cg),
    .i_flush        (i_flush),
    .i_data         (i_data),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .o_winNum       (o_winNum),
    .o_countX       (o_countX),
    .o_countY       (o_countY),
    .o_countIsect   (o_countIsect),
    .o_countSymdiff (o_countSymdiff),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_dropped      (o_dropped),
    .o_dropCount    (o_dropCount)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] fields();
    return {o_winNum, o_countX, o_countY, o_countIsect, o_countSymdiff};
  endfunction

  // One cycle: apply inputs, compare outputs to the model, advance the model, wait for next negedge.
  task automatic tick(input logic rst, input logic cg, input logic fl, input logic v,
                      input logic [7:0] d, input logic rdy);
    logic exp_ready;
    int   gap;
    i_rst = rst; i_cg = cg; i_flush = fl; i_valid = v; i_data = d; i_ready = rdy;
    #1;
    exp_ready = cg && !fl && !(mq.size() == 4 && m_valid && !rdy);
    chk("o_ready", 64'(o_ready), 64'(exp_ready));
    chk("o_valid", 64'(o_valid), 64'(m_valid));
    chk("fields", 64'(fields()), 64'(m_pkt));
    chk("o_dropped", 64'(o_dropped), 64'(DropEn && m_pend && cg));
    chk("o_dropCount", 64'(o_dropCount), DropEn ? 64'(m_count) : 64'd0);
    if (rst) begin
      mq.delete();
      m_valid = 1'b0; m_pkt = '0; m_first = 1'b1; m_prev = '0; m_count = 0; m_pend = 1'b0;
    end else if (cg) begin
      if (fl) begin
        mq.delete();
        m_valid = 1'b0; m_first = 1'b1; m_pend = 1'b0;
      end else begin
        m_pend = 1'b0;
        if (m_valid && rdy) m_valid = 1'b0;
        if (v && exp_ready) begin
          if (mq.size() == 4) begin
            m_pkt   = {mq[0], mq[1], mq[2], mq[3], d};
            m_valid = 1'b1;
            if (!m_first) begin
              gap = (int'(mq[0]) - int'(m_prev) + 255) % 256;
              if (gap != 0) begin
                m_pend  = 1'b1;
                m_count = (m_count + gap > CntMax) ? CntMax : m_count + gap;
              end
            end
            m_prev  = mq[0];
            m_first = 1'b0;
            mq.delete();
          end else begin
            mq.push_back(d);
          end
        end
      end
    end
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic idle(input logic rdy);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, rdy);
  endtask

  task automatic send_pkt(input logic [39:0] p, input logic rdy);
    for (int i = 4; i >= 0; i--) tick(1'b0, 1'b1, 1'b0, 1'b1, p[i*8 +: 8], rdy);
  endtask

  initial begin
    i_rst = 1'b1; i_cg = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_data = '0; i_ready = 1'b1;
    mq.delete();
    m_valid = 1'b0; m_pkt = '0; m_first = 1'b1; m_prev = '0; m_count = 0; m_pend = 1'b0;
    @(negedge i_clk);
    do_reset();
    chk("reset o_valid", 64'(o_valid), 64'd0);
    chk("reset fields", 64'(fields()), 64'd0);
    chk("reset o_dropCount", 64'(o_dropCount), 64'd0);

    // Basic packet, valid for exactly one cycle with consumer ready
    send_pkt(40'h00_11_22_33_44, 1'b1);
    chk("basic o_valid", 64'(o_valid), 64'd1);
    chk("basic fields", 64'(fields()), 64'h00_11_22_33_44);
    chk("basic o_dropped", 64'(o_dropped), 64'd0);
    idle(1'b1);
    chk("basic o_valid drop", 64'(o_valid), 64'd0);

    // Gap of two windows
    do_reset();
    send_pkt(40'h05_00_00_00_00, 1'b1);
    send_pkt(40'h08_00_00_00_00, 1'b1);
    chk("gap o_dropped", 64'(o_dropped), DropEn ? 64'd1 : 64'd0);
    chk("gap o_dropCount", 64'(o_dropCount), DropEn ? 64'd2 : 64'd0);
    idle(1'b1);
    chk("gap pulse end", 64'(o_dropped), 64'd0);

    // Window wrap is contiguous
    do_reset();
    send_pkt(40'hFF_01_01_01_01, 1'b1);
    send_pkt(40'h00_02_02_02_02, 1'b1);
    chk("wrap o_dropped", 64'(o_dropped), 64'd0);
    chk("wrap o_dropCount", 64'(o_dropCount), 64'd0);

    // Back-pressure on the final byte only, then no bubble
    do_reset();
    send_pkt(40'h10_11_12_13_14, 1'b0);
    for (int i = 4; i >= 1; i--) tick(1'b0, 1'b1, 1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 8'h25, 1'b0);
    chk("bp o_ready", 64'(o_ready), 64'd0);
    chk("bp fields held", 64'(fields()), 64'h10_11_12_13_14);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 8'h25, 1'b1);
    chk("bp no bubble", 64'(o_valid), 64'd1);
    chk("bp second pkt", 64'(fields()), 64'h24_23_22_21_25);
    idle(1'b1);

    // Flush mid-packet: count retained, next packet treated as first
    do_reset();
    send_pkt(40'h05_00_00_00_00, 1'b1);
    send_pkt(40'h08_00_00_00_00, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 1'b1);
    send_pkt(40'hAA_01_02_03_04, 1'b1);
    chk("flush fields", 64'(fields()), 64'hAA_01_02_03_04);
    chk("flush o_dropped", 64'(o_dropped), 64'd0);
    chk("flush o_dropCount", 64'(o_dropCount), DropEn ? 64'd2 : 64'd0);
    idle(1'b1);
    chk("flush single pkt", 64'(o_valid), 64'd0);

    // Saturation: three gaps of 99
    do_reset();
    send_pkt(40'h00_00_00_00_00, 1'b1);
    send_pkt(40'h64_00_00_00_00, 1'b1);
    send_pkt(40'hC8_00_00_00_00, 1'b1);
    send_pkt(40'h2C_00_00_00_00, 1'b1);
    chk("sat o_dropCount", 64'(o_dropCount), DropEn ? 64'hFF : 64'd0);
    send_pkt(40'h40_00_00_00_00, 1'b1);
    chk("sat held", 64'(o_dropCount), DropEn ? 64'hFF : 64'd0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      tick(($urandom % 150) == 0, ($urandom % 10) != 0, ($urandom % 40) == 0,
           ($urandom % 10) < 7, 8'($urandom), ($urandom % 10) < 6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
